// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined MIPS32 control decoder.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BLTZ  = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_AND  = 6'b011000;
  localparam logic [5:0] ALU_OR   = 6'b011110;
  localparam logic [5:0] ALU_XOR  = 6'b010110;
  localparam logic [5:0] ALU_NOR  = 6'b010001;
  localparam logic [5:0] ALU_SLL  = 6'b100000;
  localparam logic [5:0] ALU_SRL  = 6'b100001;
  localparam logic [5:0] ALU_SRA  = 6'b100011;
  localparam logic [5:0] ALU_SLT  = 6'b110101;
  localparam logic [5:0] ALU_BEQ  = 6'b110011;
  localparam logic [5:0] ALU_BNE  = 6'b110001;
  localparam logic [5:0] ALU_BLEZ = 6'b111101;
  localparam logic [5:0] ALU_BGTZ = 6'b111111;
  localparam logic [5:0] ALU_BLTZ = 6'b111011;

  localparam logic [2:0] PCSRC_SEQ    = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_JREG   = 3'd3;
  localparam logic [2:0] PCSRC_IRQ    = 3'd4;
  localparam logic [2:0] PCSRC_UNDEF  = 3'd5;

  localparam logic [1:0] REGDST_RD = 2'd0;
  localparam logic [1:0] REGDST_RT = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;
  localparam logic [1:0] REGDST_K0 = 2'd3;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;
  localparam logic [1:0] M2R_LUI = 2'd3;

  localparam logic [4:0] EXC_NONE  = 5'd0;
  localparam logic [4:0] EXC_UNDEF = 5'd31;

  typedef struct packed {
    logic       out_valid;
    logic [2:0] pc_src;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [5:0] alu_fun;
    logic       reg_wr;
    logic       alu_src1;
    logic       alu_src2;
    logic       mem_wr;
    logic       mem_rd;
    logic       ext_op;
    logic       sign;
    logic [4:0] exc_code;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Trap bundle writes PC+4 into $k0 and redirects fetch; pc_src/exc_code are patched per trap kind.
  localparam ctrl_t CTRL_TRAP = '{out_valid: 1'b1, pc_src: PCSRC_IRQ, reg_dst: REGDST_K0,
                                  mem_to_reg: M2R_PC4, alu_fun: 6'b000000, reg_wr: 1'b1,
                                  alu_src1: 1'b0, alu_src2: 1'b0, mem_wr: 1'b0, mem_rd: 1'b0,
                                  ext_op: 1'b0, sign: 1'b0, exc_code: EXC_NONE};

  typedef enum logic {ST_RUN, ST_TRAP} state_t;

endpackage

// File: rtl/irq_arbiter.sv
// Interrupt edge detection, pending latch, optional mask, lowest-index-wins encoder.
// Optional: CTRL_IRQ_MASK_EN adds a writable channel mask (otherwise all channels enabled).
module irq_arbiter #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] ack,
`ifdef CTRL_IRQ_MASK_EN
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
`endif
  output logic               any_eligible,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_IRQ-1:0] irq_d;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] eligible;

  // Edge detect and pending latch; a fresh edge beats a same-cycle acknowledge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_d <= '0;
      pend  <= '0;
    end else begin
      irq_d <= irq;
      pend  <= (pend & ~ack) | (irq & ~irq_d);
    end
  end

`ifdef CTRL_IRQ_MASK_EN
  // Mask register, all channels enabled out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mask <= '1;
    else if (mask_we)
      mask <= mask_wdata;
  end
`else
  assign mask = '1;
`endif

  assign eligible     = pend & mask;
  assign any_eligible = |eligible;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    idx = '0;
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (eligible[i-1]) idx = IDX_W'(i - 1);
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Pipelined MIPS32 control decoder: ID-stage decode, registered ID/EX bundle,
// interrupt/undef traps, post-trap bubble FSM, stall/flush handling.
// Optional: CTRL_IRQ_MASK_EN adds mask_we/mask_wdata ports.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               in_valid,
  input  logic               ker,
  input  logic               stall,
  input  logic               flush,
  input  logic [NUM_IRQ-1:0] irq,
`ifdef CTRL_IRQ_MASK_EN
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
`endif
  output logic               out_valid,
  output logic [2:0]         pc_src,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [5:0]         alu_fun,
  output logic               reg_wr,
  output logic               alu_src1,
  output logic               alu_src2,
  output logic               mem_wr,
  output logic               mem_rd,
  output logic               ext_op,
  output logic               sign,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [4:0]         exc_code
);

  ctrl_t              bun_q, bun_n, dec;
  logic               undef;
  logic [NUM_IRQ-1:0] ack_q, ack_n, ack_oh;
  state_t             state_q, state_n;
  logic               any_eligible;
  logic [IDX_W-1:0]   idx;

  irq_arbiter #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_arb (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .ack          (ack_q),
`ifdef CTRL_IRQ_MASK_EN
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
`endif
    .any_eligible (any_eligible),
    .idx          (idx)
  );

  // Instruction decode; undef flags every encoding outside the supported set.
  always_comb begin
    dec            = CTRL_BUBBLE;
    undef          = 1'b0;
    dec.out_valid  = 1'b1;
    dec.sign       = 1'b1;
    dec.reg_wr     = 1'b1;
    dec.ext_op     = (opcode != OP_ANDI);
    dec.alu_src2   = (opcode >= 6'h08);
    dec.reg_dst    = (opcode == OP_JAL) ? REGDST_RA :
                     (opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:          begin dec.alu_fun = ALU_SLL; dec.alu_src1 = 1'b1; end
          FN_SRL:          begin dec.alu_fun = ALU_SRL; dec.alu_src1 = 1'b1; end
          FN_SRA:          begin dec.alu_fun = ALU_SRA; dec.alu_src1 = 1'b1; end
          FN_JR:           begin dec.pc_src = PCSRC_JREG; dec.reg_wr = 1'b0; end
          FN_JALR:         begin dec.pc_src = PCSRC_JREG; dec.mem_to_reg = M2R_PC4; end
          FN_ADD, FN_ADDU: dec.alu_fun = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_fun = ALU_SUB;
          FN_AND:          dec.alu_fun = ALU_AND;
          FN_OR:           dec.alu_fun = ALU_OR;
          FN_XOR:          dec.alu_fun = ALU_XOR;
          FN_NOR:          dec.alu_fun = ALU_NOR;
          FN_SLT:          dec.alu_fun = ALU_SLT;
          default:         undef = 1'b1;
        endcase
      end
      OP_BLTZ:  begin dec.pc_src = PCSRC_BRANCH; dec.reg_wr = 1'b0; dec.alu_fun = ALU_BLTZ; end
      OP_BEQ:   begin dec.pc_src = PCSRC_BRANCH; dec.reg_wr = 1'b0; dec.alu_fun = ALU_BEQ;  end
      OP_BNE:   begin dec.pc_src = PCSRC_BRANCH; dec.reg_wr = 1'b0; dec.alu_fun = ALU_BNE;  end
      OP_BLEZ:  begin dec.pc_src = PCSRC_BRANCH; dec.reg_wr = 1'b0; dec.alu_fun = ALU_BLEZ; end
      OP_BGTZ:  begin dec.pc_src = PCSRC_BRANCH; dec.reg_wr = 1'b0; dec.alu_fun = ALU_BGTZ; end
      OP_J:     begin dec.pc_src = PCSRC_JUMP; dec.reg_wr = 1'b0; end
      OP_JAL:   begin dec.pc_src = PCSRC_JUMP; dec.mem_to_reg = M2R_PC4; end
      OP_ADDI, OP_ADDIU: dec.alu_fun = ALU_ADD;
      OP_SLTI, OP_SLTIU: dec.alu_fun = ALU_SLT;
      OP_ANDI:  dec.alu_fun = ALU_AND;
      OP_LUI:   dec.mem_to_reg = M2R_LUI;
      OP_LW:    begin dec.mem_rd = 1'b1; dec.mem_to_reg = M2R_MEM; end
      OP_SW:    begin dec.mem_wr = 1'b1; dec.reg_wr = 1'b0; end
      default:  undef = 1'b1;
    endcase
  end

  // One-hot acknowledge for the winning channel.
  always_comb begin
    ack_oh = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (idx == IDX_W'(i)) ack_oh[i] = 1'b1;
    end
  end

  // Next ID/EX contents and FSM: flush > stall > post-trap bubble > idle > irq > undef > decode.
  always_comb begin
    bun_n   = bun_q;
    ack_n   = '0;
    state_n = state_q;
    if (flush) begin
      bun_n   = CTRL_BUBBLE;
      state_n = ST_RUN;
    end else if (stall) begin
      bun_n = bun_q;
    end else if (state_q == ST_TRAP) begin
      bun_n   = CTRL_BUBBLE;
      state_n = ST_RUN;
    end else if (!in_valid) begin
      bun_n = CTRL_BUBBLE;
    end else if (any_eligible && !ker) begin
      bun_n          = CTRL_TRAP;
      bun_n.exc_code = 5'(idx) + 5'd1;
      ack_n          = ack_oh;
      state_n        = ST_TRAP;
    end else if (undef) begin
      bun_n          = CTRL_TRAP;
      bun_n.pc_src   = PCSRC_UNDEF;
      bun_n.exc_code = EXC_UNDEF;
      state_n        = ST_TRAP;
    end else begin
      bun_n = dec;
    end
  end

  // ID/EX register, acknowledge pulse and FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bun_q   <= CTRL_BUBBLE;
      ack_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      bun_q   <= bun_n;
      ack_q   <= ack_n;
      state_q <= state_n;
    end
  end

  assign out_valid  = bun_q.out_valid;
  assign pc_src     = bun_q.pc_src;
  assign reg_dst    = bun_q.reg_dst;
  assign mem_to_reg = bun_q.mem_to_reg;
  assign alu_fun    = bun_q.alu_fun;
  assign reg_wr     = bun_q.reg_wr;
  assign alu_src1   = bun_q.alu_src1;
  assign alu_src2   = bun_q.alu_src2;
  assign mem_wr     = bun_q.mem_wr;
  assign mem_rd     = bun_q.mem_rd;
  assign ext_op     = bun_q.ext_op;
  assign sign       = bun_q.sign;
  assign exc_code   = bun_q.exc_code;
  assign irq_ack    = ack_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe with an expected-result queue.
module tb_decode_ctrl_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       in_valid, ker, stall, flush;
  logic [3:0] irq;
`ifdef CTRL_IRQ_MASK_EN
  logic       mask_we;
  logic [3:0] mask_wdata;
`endif
  logic       out_valid, reg_wr, alu_src1, alu_src2, mem_wr, mem_rd, ext_op, sign;
  logic [2:0] pc_src;
  logic [1:0] reg_dst, mem_to_reg;
  logic [5:0] alu_fun;
  logic [3:0] irq_ack;
  logic [4:0] exc_code;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [29:0] sbq[$];

  always #5 clk = ~clk;

  decode_ctrl_pipe #(.NUM_IRQ(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .in_valid(in_valid),
    .ker(ker), .stall(stall), .flush(flush), .irq(irq),
`ifdef CTRL_IRQ_MASK_EN
    .mask_we(mask_we), .mask_wdata(mask_wdata),
`endif
    .out_valid(out_valid), .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_fun(alu_fun), .reg_wr(reg_wr), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .ext_op(ext_op), .sign(sign),
    .irq_ack(irq_ack), .exc_code(exc_code)
  );

  // Flags order: reg_wr, alu_src1, alu_src2, mem_wr, mem_rd, ext_op, sign.
  function automatic logic [29:0] mk(input logic ov, input logic [2:0] ps, input logic [1:0] rd,
                                     input logic [1:0] m2r, input logic [5:0] af,
                                     input logic [6:0] fl, input logic [4:0] ex,
                                     input logic [3:0] ak);
    return {ov, ps, rd, m2r, af, fl, ex, ak};
  endfunction

  function automatic logic [29:0] trap(input logic [4:0] ex, input logic [3:0] ak);
    return mk(1'b1, 3'd4, 2'd3, 2'd2, 6'd0, 7'b1000000, ex, ak);
  endfunction

  logic [29:0] E_BUB, E_ADD, E_BEQ, E_LW, E_SLL, E_SRA, E_JAL, E_J, E_JR, E_JALR;
  logic [29:0] E_ANDI, E_LUI, E_SW, E_BLTZ, E_BGTZ, E_NOR, E_SLTI, E_UNDEF;

  task automatic check(input string tag);
    logic [29:0] obs, expv;
    obs  = {out_valid, pc_src, reg_dst, mem_to_reg, alu_fun, reg_wr, alu_src1, alu_src2,
            mem_wr, mem_rd, ext_op, sign, exc_code, irq_ack};
    expv = sbq.pop_front();
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Push the expectation for the inputs currently driven, clock once, compare.
  task automatic tick(input logic [29:0] expv, input string tag);
    sbq.push_back(expv);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  task automatic ins(input logic [5:0] op, input logic [5:0] fn);
    opcode   = op;
    funct    = fn;
    in_valid = 1'b1;
  endtask

  initial begin
    E_BUB   = '0;
    E_ADD   = mk(1, 3'd0, 2'd0, 2'd0, 6'b000000, 7'b1000011, 5'd0, 4'd0);
    E_BEQ   = mk(1, 3'd1, 2'd1, 2'd0, 6'b110011, 7'b0000011, 5'd0, 4'd0);
    E_LW    = mk(1, 3'd0, 2'd1, 2'd1, 6'b000000, 7'b1010111, 5'd0, 4'd0);
    E_SLL   = mk(1, 3'd0, 2'd0, 2'd0, 6'b100000, 7'b1100011, 5'd0, 4'd0);
    E_SRA   = mk(1, 3'd0, 2'd0, 2'd0, 6'b100011, 7'b1100011, 5'd0, 4'd0);
    E_JAL   = mk(1, 3'd2, 2'd2, 2'd2, 6'b000000, 7'b1000011, 5'd0, 4'd0);
    E_J     = mk(1, 3'd2, 2'd1, 2'd0, 6'b000000, 7'b0000011, 5'd0, 4'd0);
    E_JR    = mk(1, 3'd3, 2'd0, 2'd0, 6'b000000, 7'b0000011, 5'd0, 4'd0);
    E_JALR  = mk(1, 3'd3, 2'd0, 2'd2, 6'b000000, 7'b1000011, 5'd0, 4'd0);
    E_ANDI  = mk(1, 3'd0, 2'd1, 2'd0, 6'b011000, 7'b1010001, 5'd0, 4'd0);
    E_LUI   = mk(1, 3'd0, 2'd1, 2'd3, 6'b000000, 7'b1010011, 5'd0, 4'd0);
    E_SW    = mk(1, 3'd0, 2'd1, 2'd0, 6'b000000, 7'b0011011, 5'd0, 4'd0);
    E_BLTZ  = mk(1, 3'd1, 2'd1, 2'd0, 6'b111011, 7'b0000011, 5'd0, 4'd0);
    E_BGTZ  = mk(1, 3'd1, 2'd1, 2'd0, 6'b111111, 7'b0000011, 5'd0, 4'd0);
    E_NOR   = mk(1, 3'd0, 2'd0, 2'd0, 6'b010001, 7'b1000011, 5'd0, 4'd0);
    E_SLTI  = mk(1, 3'd0, 2'd1, 2'd0, 6'b110101, 7'b1010011, 5'd0, 4'd0);
    E_UNDEF = mk(1, 3'd5, 2'd3, 2'd2, 6'b000000, 7'b1000000, 5'd31, 4'd0);

    reset = 1'b0; opcode = '0; funct = '0; in_valid = 1'b0;
    ker = 1'b0; stall = 1'b0; flush = 1'b0; irq = '0;
`ifdef CTRL_IRQ_MASK_EN
    mask_we = 1'b0; mask_wdata = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    sbq.push_back(E_BUB);
    check("reset");
    reset = 1'b1;

    // Plain decode
    ins(6'h00, 6'h20); tick(E_ADD,  "add");
    ins(6'h04, 6'h00); tick(E_BEQ,  "beq");
    ins(6'h23, 6'h00); tick(E_LW,   "lw");
    ins(6'h00, 6'h00); tick(E_SLL,  "sll");
    ins(6'h00, 6'h03); tick(E_SRA,  "sra");
    ins(6'h03, 6'h00); tick(E_JAL,  "jal");
    ins(6'h02, 6'h00); tick(E_J,    "j");
    ins(6'h00, 6'h08); tick(E_JR,   "jr");
    ins(6'h00, 6'h09); tick(E_JALR, "jalr");
    ins(6'h0c, 6'h00); tick(E_ANDI, "andi");
    ins(6'h0f, 6'h00); tick(E_LUI,  "lui");
    ins(6'h2b, 6'h00); tick(E_SW,   "sw");
    ins(6'h01, 6'h00); tick(E_BLTZ, "bltz");
    ins(6'h07, 6'h00); tick(E_BGTZ, "bgtz");
    ins(6'h00, 6'h27); tick(E_NOR,  "nor");
    ins(6'h0a, 6'h00); tick(E_SLTI, "slti");
    in_valid = 1'b0;   tick(E_BUB,  "idle_bubble");

    // Two channels rise together: lowest index first, bubble after each trap
    ins(6'h00, 6'h20); irq = 4'b0110; tick(E_ADD, "irq_edge_latch");
    tick(trap(5'd2, 4'b0010), "irq1_trap");
    tick(E_BUB, "irq1_bubble");
    tick(trap(5'd3, 4'b0100), "irq2_trap");
    tick(E_BUB, "irq2_bubble");
    tick(E_ADD, "irq_drained");
    irq = 4'b0000; in_valid = 1'b0; tick(E_BUB, "irq_quiet");

    // Undef traps, including in kernel mode
    ins(6'h3f, 6'h00); ker = 1'b1; tick(E_UNDEF, "undef_ker");
    tick(E_BUB, "undef_bubble");
    ins(6'h00, 6'h01); ker = 1'b0; tick(E_UNDEF, "undef_rfunct");
    ins(6'h00, 6'h20); tick(E_BUB, "undef_bubble2");

    // Kernel mode blocks interrupts until it drops
    ker = 1'b1; irq = 4'b0001; tick(E_ADD, "ker_edge");
    tick(E_ADD, "ker_blocked");
    ker = 1'b0; tick(trap(5'd1, 4'b0001), "ker_released");
    tick(E_BUB, "ker_bubble");
    irq = 4'b0000; tick(E_ADD, "ker_drained");

    // Stall during a trap: hold bundle, acknowledge not repeated
    irq = 4'b1000; tick(E_ADD, "stall_edge");
    tick(trap(5'd4, 4'b1000), "stall_trap");
    stall = 1'b1; tick(trap(5'd4, 4'b0000), "stall_hold1");
    tick(trap(5'd4, 4'b0000), "stall_hold2");
    stall = 1'b0; tick(E_BUB, "stall_release_bubble");
    irq = 4'b0000; tick(E_ADD, "stall_no_retrap");

    // Stall holds a normal bundle; stall+flush gives a bubble
    ins(6'h23, 6'h00); stall = 1'b1; tick(E_ADD, "stall_hold_add");
    flush = 1'b1; tick(E_BUB, "stall_flush");
    stall = 1'b0; flush = 1'b0; ins(6'h23, 6'h00); tick(E_LW, "after_flush");

    // Flush in TRAP returns straight to RUN
    ins(6'h3f, 6'h00); tick(E_UNDEF, "flush_trap");
    ins(6'h00, 6'h20); flush = 1'b1; tick(E_BUB, "flush_in_trap");
    flush = 1'b0; tick(E_ADD, "flush_to_run");

    // New edge coinciding with the acknowledge of the same channel stays pending
    irq = 4'b0001; tick(E_ADD, "setwins_edge");
    irq = 4'b0000; tick(trap(5'd1, 4'b0001), "setwins_trap1");
    irq = 4'b0001; tick(E_BUB, "setwins_bubble");
    tick(trap(5'd1, 4'b0001), "setwins_trap2");
    tick(E_BUB, "setwins_bubble2");
    irq = 4'b0000; tick(E_ADD, "setwins_drained");

`ifdef CTRL_IRQ_MASK_EN
    // Masked channel stays pending until unmasked
    mask_we = 1'b1; mask_wdata = 4'b1110; tick(E_ADD, "mask_write");
    mask_we = 1'b0; irq = 4'b0001; tick(E_ADD, "mask_edge");
    tick(E_ADD, "mask_blocked");
    mask_we = 1'b1; mask_wdata = 4'b1111; tick(E_ADD, "mask_unmask_write");
    mask_we = 1'b0; tick(trap(5'd1, 4'b0001), "mask_trap");
    irq = 4'b0000; tick(E_BUB, "mask_bubble");
`endif

    // Asynchronous reset mid-operation loses a pending interrupt
    irq = 4'b0010; tick(E_ADD, "areset_edge");
    #3;
    reset = 1'b0; irq = 4'b0000; in_valid = 1'b0;
    #1;
    sbq.push_back(E_BUB);
    check("async_reset");
    @(negedge clk);
    reset = 1'b1;
    tick(E_BUB, "post_reset_idle");
    ins(6'h00, 6'h20); tick(E_ADD, "pend_lost1");
    tick(E_ADD, "pend_lost2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
